m68k_bus_ctrl: RTL and testbench

Bus cycle controller for the fx68k CPU core. It generates the phi1/phi2 clock enables and decodes the CPU address into ROM/RAM/IO selects. It sequences each bus cycle with a per-region wait-state DTACKn, a VPAn handshake for the IO region, and a BERRn timeout for unmapped accesses. It sits between the CPU core and the ROM, RAM and LED/IO ports, replacing the free-running DTACK and combinational decode.

---
 rtl/m68k_bus_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_m68k_bus_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/m68k_bus_ctrl.sv
// fx68k bus cycle controller: phi1/phi2 enables, address decode and per-region
// DTACKn/VPAn/BERRn sequencing with RAM/IO write strobes.
module m68k_bus_ctrl #(
    parameter int unsigned ROM_WAIT = 1,
    parameter int unsigned RAM_WAIT = 0,
    parameter int unsigned TIMEOUT  = 63
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        phi1,
    output logic        phi2,
    input  logic [23:1] cpu_addr,
    input  logic        cpu_as_n,
    input  logic        cpu_rw,
    input  logic        cpu_uds_n,
    input  logic        cpu_lds_n,
    input  logic        cpu_vma_n,
    output logic        dtack_n,
    output logic        vpa_n,
    output logic        berr_n,
    output logic        rom_cs,
    output logic        ram_cs,
    output logic        ram_we,
    output logic [1:0]  ram_mask,
    output logic        io_we
);

    localparam int unsigned CNT_W     = 8;
    localparam int unsigned CNT_MAX   = 255;
    localparam int unsigned TMO_CLAMP = (TIMEOUT < 1) ? 1 : ((TIMEOUT > CNT_MAX) ? CNT_MAX : TIMEOUT);
    localparam int unsigned ROM_CLAMP = (ROM_WAIT > CNT_MAX) ? CNT_MAX : ROM_WAIT;
    localparam int unsigned RAM_CLAMP = (RAM_WAIT > CNT_MAX) ? CNT_MAX : RAM_WAIT;
    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TMO_CLAMP);
    localparam logic [CNT_W-1:0] ROM_CNT = CNT_W'(ROM_CLAMP);
    localparam logic [CNT_W-1:0] RAM_CNT = CNT_W'(RAM_CLAMP);

    typedef enum logic [2:0] {IDLE, WAIT, ACK, IO, ERR} state_t;
    typedef enum logic [1:0] {REG_ROM, REG_RAM, REG_IO, REG_NONE} region_t;

    state_t             state_q, state_d;
    region_t            region_q, region_d, region_c;
    logic [CNT_W-1:0]   cnt_q, cnt_d, wait_c;
    logic               rw_q, rw_d;
    logic               tmo_q, tmo_d;
    logic               armed_q, armed_d;
    logic               first_q, first_d;
    logic               io_done_q, io_done_d;
    logic               phi1_q, phi1_d, phi2_q, phi2_d;
    logic               dtack_n_q, dtack_n_d;
    logic               vpa_n_q, vpa_n_d;
    logic               berr_n_q, berr_n_d;
    logic               ram_we_q, ram_we_d;
    logic [1:0]         ram_mask_q, ram_mask_d;
    logic               io_we_q, io_we_d;
    logic               unused_addr;

    // Upper and lower address bits do not take part in decode, so regions mirror.
    assign unused_addr = ^{cpu_addr[23:16], cpu_addr[11:1]};

    always_comb begin
        case (cpu_addr[15:12])
            4'h0:    region_c = REG_ROM;
            4'h1:    region_c = REG_RAM;
            4'h2:    region_c = REG_IO;
            default: region_c = REG_NONE;
        endcase
        wait_c = (region_c == REG_ROM) ? ROM_CNT : RAM_CNT;
    end

    assign rom_cs = (region_c == REG_ROM);
    assign ram_cs = (region_c == REG_RAM);

    always_comb begin
        state_d    = state_q;
        region_d   = region_q;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        tmo_d      = tmo_q;
        armed_d    = armed_q | cpu_as_n;
        first_d    = 1'b0;
        io_done_d  = io_done_q;
        phi1_d     = ~phi1_q;
        phi2_d     = phi1_q;
        dtack_n_d  = 1'b1;
        vpa_n_d    = 1'b1;
        berr_n_d   = 1'b1;
        ram_we_d   = 1'b0;
        ram_mask_d = 2'b00;
        io_we_d    = 1'b0;

        case (state_q)
            IDLE: begin
                io_done_d = 1'b0;
                // A new cycle needs a fresh falling strobe, not a stuck-low one.
                if (!cpu_as_n && armed_q) begin
                    armed_d  = 1'b0;
                    region_d = region_c;
                    rw_d     = cpu_rw;
                    tmo_d    = 1'b0;
                    case (region_c)
                        REG_ROM, REG_RAM: begin
                            if (wait_c == '0) begin
                                state_d = ACK;
                                first_d = 1'b1;
                            end else begin
                                state_d = WAIT;
                                cnt_d   = wait_c;
                            end
                        end
                        REG_IO:  state_d = IO;
                        default: begin
                            state_d = WAIT;
                            cnt_d   = TMO_CNT;
                            tmo_d   = 1'b1;
                        end
                    endcase
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cpu_as_n) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = tmo_q ? ERR : ACK;
                    first_d = ~tmo_q;
                end
            end
            ACK: begin
                if (cpu_as_n) begin
                    state_d = IDLE;
                end else begin
                    dtack_n_d = 1'b0;
                    if (first_q && (region_q == REG_RAM) && !rw_q) begin
                        ram_we_d   = 1'b1;
                        ram_mask_d = {~cpu_uds_n, ~cpu_lds_n};
                    end
                end
            end
            IO: begin
                if (cpu_as_n) begin
                    state_d = IDLE;
                end else begin
                    vpa_n_d = 1'b0;
                    if (!cpu_vma_n && !rw_q && !io_done_q) begin
                        io_we_d   = 1'b1;
                        io_done_d = 1'b1;
                    end
                end
            end
            ERR: begin
                if (cpu_as_n) begin
                    state_d = IDLE;
                end else begin
                    berr_n_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            region_q   <= REG_NONE;
            cnt_q      <= '0;
            rw_q       <= 1'b1;
            tmo_q      <= 1'b0;
            armed_q    <= 1'b0;
            first_q    <= 1'b0;
            io_done_q  <= 1'b0;
            phi1_q     <= 1'b0;
            phi2_q     <= 1'b0;
            dtack_n_q  <= 1'b1;
            vpa_n_q    <= 1'b1;
            berr_n_q   <= 1'b1;
            ram_we_q   <= 1'b0;
            ram_mask_q <= 2'b00;
            io_we_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            region_q   <= region_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            tmo_q      <= tmo_d;
            armed_q    <= armed_d;
            first_q    <= first_d;
            io_done_q  <= io_done_d;
            phi1_q     <= phi1_d;
            phi2_q     <= phi2_d;
            dtack_n_q  <= dtack_n_d;
            vpa_n_q    <= vpa_n_d;
            berr_n_q   <= berr_n_d;
            ram_we_q   <= ram_we_d;
            ram_mask_q <= ram_mask_d;
            io_we_q    <= io_we_d;
        end
    end

    assign phi1     = phi1_q;
    assign phi2     = phi2_q;
    assign dtack_n  = dtack_n_q;
    assign vpa_n    = vpa_n_q;
    assign berr_n   = berr_n_q;
    assign ram_we   = ram_we_q;
    assign ram_mask = ram_mask_q;
    assign io_we    = io_we_q;

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Scoreboard bench for m68k_bus_ctrl: stimulus queues expected handshake events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_m68k_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:1] cpu_addr;
    logic        cpu_as_n, cpu_rw, cpu_uds_n, cpu_lds_n, cpu_vma_n;

    logic        phi1, phi2, dtack_n, vpa_n, berr_n, rom_cs, ram_cs, ram_we, io_we;
    logic [1:0]  ram_mask;
    logic        phi1_5, phi2_5, dtack_n5, vpa_n5, berr_n5, rom_cs5, ram_cs5, ram_we5, io_we5;
    logic [1:0]  ram_mask5;

    always #5 clk = ~clk;

    m68k_bus_ctrl #(.ROM_WAIT(1), .RAM_WAIT(0), .TIMEOUT(63)) u_dut (
        .clk(clk), .rst_n(rst_n), .phi1(phi1), .phi2(phi2), .cpu_addr(cpu_addr),
        .cpu_as_n(cpu_as_n), .cpu_rw(cpu_rw), .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n),
        .cpu_vma_n(cpu_vma_n), .dtack_n(dtack_n), .vpa_n(vpa_n), .berr_n(berr_n),
        .rom_cs(rom_cs), .ram_cs(ram_cs), .ram_we(ram_we), .ram_mask(ram_mask), .io_we(io_we)
    );

    m68k_bus_ctrl #(.ROM_WAIT(5), .RAM_WAIT(0), .TIMEOUT(63)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .phi1(phi1_5), .phi2(phi2_5), .cpu_addr(cpu_addr),
        .cpu_as_n(cpu_as_n), .cpu_rw(cpu_rw), .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n),
        .cpu_vma_n(cpu_vma_n), .dtack_n(dtack_n5), .vpa_n(vpa_n5), .berr_n(berr_n5),
        .rom_cs(rom_cs5), .ram_cs(ram_cs5), .ram_we(ram_we5), .ram_mask(ram_mask5), .io_we(io_we5)
    );

    typedef enum int {EV_DT_FALL, EV_DT_RISE, EV_VPA_FALL, EV_VPA_RISE,
                      EV_BERR_FALL, EV_BERR_RISE, EV_RAM_WE, EV_IO_WE} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        int         cyc;
        logic [1:0] mask;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    logic phi1_m, phi2_m;
    logic p_dt = 1'b1, p_vpa = 1'b1, p_berr = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference phase generator: phi1 toggles, phi2 trails it by one clk.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phi1_m <= 1'b0;
            phi2_m <= 1'b0;
        end else begin
            phi1_m <= ~phi1_m;
            phi2_m <= phi1_m;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input ev_kind_t k, input int c, input logic [1:0] m);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.mask = m;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_t k, input logic [1:0] m);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL event: got kind=%0d cyc=%0d, want no event", k, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || (k == EV_RAM_WE && e.mask !== m)) begin
                bad++;
                $display("FAIL event: got kind=%0d cyc=%0d mask=%b, want kind=%0d cyc=%0d mask=%b",
                         k, cyc, m, e.kind, e.cyc, e.mask);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) check("phi", {30'd0, phi1, phi2}, {30'd0, phi1_m, phi2_m});
        if (p_dt && !dtack_n)  observe(EV_DT_FALL, 2'b00);
        if (!p_dt && dtack_n)  observe(EV_DT_RISE, 2'b00);
        if (p_vpa && !vpa_n)   observe(EV_VPA_FALL, 2'b00);
        if (!p_vpa && vpa_n)   observe(EV_VPA_RISE, 2'b00);
        if (p_berr && !berr_n) observe(EV_BERR_FALL, 2'b00);
        if (!p_berr && berr_n) observe(EV_BERR_RISE, 2'b00);
        if (ram_we)            observe(EV_RAM_WE, ram_mask);
        if (io_we)             observe(EV_IO_WE, 2'b00);
        p_dt   <= dtack_n;
        p_vpa  <= vpa_n;
        p_berr <= berr_n;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_addr(input logic [23:0] a);
        cpu_addr = a[23:1];
    endtask

    // Called at a negedge: the following posedge samples the strobe low.
    task automatic start(input logic [23:0] a, input logic rw, input logic u, input logic l,
                         output int t);
        set_addr(a);
        cpu_rw    = rw;
        cpu_uds_n = u;
        cpu_lds_n = l;
        cpu_as_n  = 1'b0;
        t = cyc + 1;
    endtask

    task automatic release_as(output int r);
        cpu_as_n = 1'b1;
        r = cyc + 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t, r, seen;
        logic dt5_low;
        rst_n = 1'b0; cpu_as_n = 1'b1; cpu_rw = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
        cpu_vma_n = 1'b1; cpu_addr = '0;
        wait_clk(2);
        check("reset_outs", {23'd0, phi1, phi2, dtack_n, vpa_n, berr_n, ram_we, io_we, ram_mask},
              32'b0_0111_0000);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("phi1_seq", {31'd0, phi1}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("phi2_seq", {31'd0, phi2}, (i % 2 == 1) ? 32'd1 : 32'd0);
        end

        // Decode, including mirrored upper address bits.
        set_addr(24'h000010); #1 check("dec_rom",    {30'd0, rom_cs, ram_cs}, 32'b10);
        set_addr(24'h001004); #1 check("dec_ram",    {30'd0, rom_cs, ram_cs}, 32'b01);
        set_addr(24'h3F1000); #1 check("dec_ram_mir",{30'd0, rom_cs, ram_cs}, 32'b01);
        set_addr(24'h120010); #1 check("dec_rom_mir",{30'd0, rom_cs, ram_cs}, 32'b10);
        set_addr(24'h002000); #1 check("dec_io",     {30'd0, rom_cs, ram_cs}, 32'b00);
        set_addr(24'h00F000); #1 check("dec_none",   {30'd0, rom_cs, ram_cs}, 32'b00);

        // ROM read, one wait state.
        @(negedge clk);
        start(24'h000010, 1'b1, 1'b0, 1'b0, t); push(EV_DT_FALL, t + 2, 2'b00);
        wait_clk(4); release_as(r); push(EV_DT_RISE, r, 2'b00);
        wait_clk(3);

        // RAM upper-byte write, held low long enough to expose a second pulse.
        start(24'h001004, 1'b0, 1'b0, 1'b1, t);
        push(EV_DT_FALL, t + 1, 2'b00); push(EV_RAM_WE, t + 1, 2'b10);
        wait_clk(6); release_as(r); push(EV_DT_RISE, r, 2'b00);
        wait_clk(2);

        // RAM word write at a mirrored address.
        start(24'h7F1FFE, 1'b0, 1'b0, 1'b0, t);
        push(EV_DT_FALL, t + 1, 2'b00); push(EV_RAM_WE, t + 1, 2'b11);
        wait_clk(2); release_as(r); push(EV_DT_RISE, r, 2'b00);
        wait_clk(2);

        // ROM write and RAM read: acknowledge only, no write strobe.
        start(24'h000100, 1'b0, 1'b0, 1'b0, t); push(EV_DT_FALL, t + 2, 2'b00);
        wait_clk(3); release_as(r); push(EV_DT_RISE, r, 2'b00);
        wait_clk(2);
        start(24'h001000, 1'b1, 1'b0, 1'b0, t); push(EV_DT_FALL, t + 1, 2'b00);
        wait_clk(3); release_as(r); push(EV_DT_RISE, r, 2'b00);
        wait_clk(2);

        // IO write: vma held low 4 clks yields one io_we.
        start(24'h002000, 1'b0, 1'b0, 1'b0, t); push(EV_VPA_FALL, t + 1, 2'b00);
        wait_clk(2); cpu_vma_n = 1'b0; push(EV_IO_WE, t + 2, 2'b00);
        wait_clk(4); cpu_vma_n = 1'b1;
        wait_clk(1); release_as(r); push(EV_VPA_RISE, r, 2'b00);
        wait_clk(2);

        // IO read: vpa only.
        start(24'h002ABC, 1'b1, 1'b0, 1'b0, t); push(EV_VPA_FALL, t + 1, 2'b00);
        wait_clk(1); cpu_vma_n = 1'b0;
        wait_clk(3); cpu_vma_n = 1'b1; release_as(r); push(EV_VPA_RISE, r, 2'b00);
        wait_clk(2);

        // Unmapped read times out into bus error.
        start(24'h005000, 1'b1, 1'b0, 1'b0, t); push(EV_BERR_FALL, t + 64, 2'b00);
        wait_clk(70); release_as(r); push(EV_BERR_RISE, r, 2'b00);
        wait_clk(2);

        // Abort mid-wait on the 5-wait instance; the 1-wait instance completes.
        start(24'h000010, 1'b1, 1'b0, 1'b0, t); push(EV_DT_FALL, t + 2, 2'b00);
        dt5_low = 1'b0;
        repeat (3) begin @(negedge clk); if (!dtack_n5) dt5_low = 1'b1; end
        release_as(r); push(EV_DT_RISE, r, 2'b00);
        repeat (8) begin @(negedge clk); if (!dtack_n5) dt5_low = 1'b1; end
        check("abort_no_dtack", {31'd0, dt5_low}, 32'd0);

        // Aborted instance returns to idle: next access acknowledges after 5 waits.
        start(24'h000010, 1'b1, 1'b0, 1'b0, t); push(EV_DT_FALL, t + 2, 2'b00);
        seen = -1;
        for (int i = 0; i < 20 && seen < 0; i++) begin
            @(negedge clk);
            if (!dtack_n5) seen = cyc;
        end
        check("wait5_latency", seen, t + 6);
        release_as(r); push(EV_DT_RISE, r, 2'b00);
        wait_clk(2);

        // Async reset while acknowledging, then a stuck-low strobe must not re-trigger.
        start(24'h001000, 1'b1, 1'b0, 1'b0, t); push(EV_DT_FALL, t + 1, 2'b00);
        wait_clk(2);
        #2 rst_n = 1'b0;
        push(EV_DT_RISE, cyc + 1, 2'b00);
        #1 check("async_rst_dtack", {31'd0, dtack_n}, 32'd1);
        wait_clk(2); rst_n = 1'b1;
        wait_clk(5); cpu_as_n = 1'b1;
        wait_clk(2);

        // Recovery access after reset.
        start(24'h000010, 1'b1, 1'b0, 1'b0, t); push(EV_DT_FALL, t + 2, 2'b00);
        wait_clk(3); release_as(r); push(EV_DT_RISE, r, 2'b00);
        wait_clk(3);

        check("events_left", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
